bg_index_fetch: RTL and testbench
=================================

// Module: bg_index_fetch
// PURPOSE
//  Producer side of the palette-index interface: turns VGA scan coordinates into 4-bit palette indices.
//  Reads a background image from synchronous on-chip ROM, with a per-frame horizontal scroll that wraps.
//  Delivers the index plus the delayed DrawX/DrawY, pipeline-aligned, to color_mapper.
//  Sits between the VGA controller and the palette/colour-mapping stage.
// PARAMETERS
//  IMG_W        320   source image width in pixels
//  IMG_H        240   source image height in pixels
//  SCALE_SHIFT  1     screen-to-image downscale (DrawX>>SCALE_SHIFT)
//  IDX_W        4     palette index width
//  ADDR_W       17    ROM address width (>= clog2(IMG_W*IMG_H))
// PORTS
//  Clk          in   1       pixel clock
//  Reset        in   1       asynchronous, active-high reset
//  DrawX        in   10      current scan column
//  DrawY        in   10      current scan row
//  pixel_valid  in   1       1 = visible region (blank_n)
//  frame_start  in   1       one-cycle pulse at start of vertical blank
//  scroll_en    in   1       enable scroll advance at frame_start
//  scroll_step  in   4       columns advanced per frame
//  rom_addr     out  ADDR_W  ROM read address (registered)
//  rom_data     in   IDX_W   ROM read data, valid 1 cycle after rom_addr
//  idx_out      out  IDX_W   palette index for DrawX_d/DrawY_d
//  idx_valid    out  1       idx_out belongs to a visible pixel
//  DrawX_d      out  10      DrawX delayed to align with idx_out
//  DrawY_d      out  10      DrawY delayed to align with idx_out
// BEHAVIOUR
//  - Reset (async, asserts immediately): scroll_x=0; rom_addr=0; idx_out=0; idx_valid=0; DrawX_d=DrawY_d=0; all pipeline valids cleared.
//  - Pipeline, fixed latency 3 cycles, one pixel per cycle, no stalls:
//    S0 (edge N+1): compute col/row, register rom_addr, valid, out_of_range flag, coords.
//    S1 (edge N+2): ROM returns rom_data; stage registers carry flags and coords.
//    S2 (edge N+3): register idx_out/idx_valid/DrawX_d/DrawY_d.
//  - col = (DrawX>>SCALE_SHIFT) + scroll_x; subtract IMG_W once if >= IMG_W. Both terms < IMG_W, so a single subtract suffices.
//  - row = DrawY>>SCALE_SHIFT; rom_addr = row*IMG_W + col. Truncate to ADDR_W; no overflow within legal range.
//  - row >= IMG_H or col source >= IMG_W: out_of_range; idx_out=0 (transparent), rom_addr holds its previous value.
//  - pixel_valid=0: idx_valid=0, idx_out=0; DrawX_d/DrawY_d still track the inputs.
//  - scroll_x update on frame_start=1 && scroll_en=1: scroll_x <= (scroll_x+scroll_step) mod IMG_W, wrapping at IMG_W.
//    Takes effect for pixels sampled on the cycle after frame_start.
//  - frame_start with pixel_valid=1 simultaneously is legal. That pixel uses the old scroll_x, and the pipeline is not disturbed.
//  - Reset mid-frame: in-flight pixels are discarded, idx_valid=0 until 3 cycles after the first valid pixel following release.
// CONFIGURATION
//  - BG_FETCH_MIRROR_EN defined: adds input port mirror_x (1 bit), sampled every cycle with DrawX.
//    When 1, col' = IMG_W-1-col, applied after the scroll wrap.
//  - Macro undefined: port mirror_x is absent, col is used unmodified, latency is unchanged.
// STRUCTURE
//  - Package bg_fetch_pkg: IMG_W/IMG_H/SCALE_SHIFT defaults, typedef coord_t (logic[9:0]),
//    typedef pal_idx_t (logic[IDX_W-1:0]), localparam TRANSPARENT_IDX = 0.
//  - Sub-module bg_addr_calc: combinational col/row/wrap/mirror/out_of_range/addr computation; S0 registers its outputs.
//  - The ROM is external: palette image memory instantiated at top level.
// TESTING
//  1. Reset: scroll_x=0, DrawX=0, DrawY=0, pixel_valid=1 -> rom_addr=0 at N+1; idx_out=rom_data[0], idx_valid=1 at N+3.
//  2. DrawX=10, DrawY=4, scroll_x=0 -> rom_addr=2*320+5=645; DrawX_d=10, DrawY_d=4 aligned with idx_out.
//  3. scroll_step=15, scroll_en=1, 22 frame_start pulses -> scroll_x=330 mod 320=10;
//     DrawX=630 -> col=(315+10)-320=5.
//  4. DrawY=480 (row 240) -> idx_out=0; pixel_valid=0 -> idx_valid=0, idx_out=0.
//  5. frame_start and valid pixel in same cycle -> that pixel uses old scroll_x, the next pixel uses the new one.
//     Reset mid-line -> all outputs 0 immediately.
//  6. BG_FETCH_MIRROR_EN defined, mirror_x=1, DrawX=0, scroll_x=0 -> col=319, rom_addr=319 for DrawY=0.

Source files
------------

// File: rtl/bg_fetch_pkg.sv
// ---------------------------------------------------------------------------
// bg_fetch_pkg
//   Shared types and default geometry for the background index fetch path.
//   DEF_IMG_W / DEF_IMG_H   : source image size in pixels
//   DEF_SCALE_SHIFT         : screen-to-image downscale (DrawX >> shift)
//   DEF_IDX_W / DEF_ADDR_W  : palette index width, ROM address width
//   coord_t                 : 10-bit VGA scan coordinate
//   pal_idx_t               : palette index
//   TRANSPARENT_IDX         : index emitted for blanked / off-image pixels
// ---------------------------------------------------------------------------
package bg_fetch_pkg;

  localparam int DEF_IMG_W       = 320;
  localparam int DEF_IMG_H       = 240;
  localparam int DEF_SCALE_SHIFT = 1;
  localparam int DEF_IDX_W       = 4;
  localparam int DEF_ADDR_W      = 17;

  typedef logic [9:0]           coord_t;
  typedef logic [DEF_IDX_W-1:0] pal_idx_t;

  localparam pal_idx_t TRANSPARENT_IDX = '0;

endpackage

// File: rtl/bg_addr_calc.sv
// ---------------------------------------------------------------------------
// bg_addr_calc
//   Combinational scan-coordinate to ROM-address mapping.
//   draw_x_i / draw_y_i : scan coordinates
//   scroll_x_i          : current horizontal scroll (always < IMG_W)
//   mirror_i            : reflect the column after the scroll wrap
//   addr_o              : row*IMG_W + col, truncated to ADDR_W
//   oor_o               : source column or row lies outside the image
// ---------------------------------------------------------------------------
module bg_addr_calc
  import bg_fetch_pkg::*;
#(
  parameter int IMG_W       = DEF_IMG_W,
  parameter int IMG_H       = DEF_IMG_H,
  parameter int SCALE_SHIFT = DEF_SCALE_SHIFT,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int SX_W        = $clog2(DEF_IMG_W)
) (
  input  coord_t            draw_x_i,
  input  coord_t            draw_y_i,
  input  logic [SX_W-1:0]   scroll_x_i,
  input  logic              mirror_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              oor_o
);

  // One bit of headroom over a coordinate: source column plus scroll
  // reaches at most 511 + IMG_W-1.
  localparam int CW = 11;

  logic [CW-1:0] src_col;
  logic [CW-1:0] row;
  logic [CW-1:0] sum_col;
  logic [CW-1:0] col;

  always_comb begin
    src_col = CW'(draw_x_i >> SCALE_SHIFT);
    row     = CW'(draw_y_i >> SCALE_SHIFT);
    sum_col = src_col + CW'(scroll_x_i);
    // Both terms are below IMG_W for in-range pixels, so one subtract wraps.
    col     = (sum_col >= CW'(IMG_W)) ? (sum_col - CW'(IMG_W)) : sum_col;
    if (mirror_i) begin
      col = CW'(IMG_W - 1) - col;
    end
    oor_o  = (src_col >= CW'(IMG_W)) || (row >= CW'(IMG_H));
    addr_o = ADDR_W'(row) * ADDR_W'(IMG_W) + ADDR_W'(col);
  end

endmodule

// File: rtl/bg_index_fetch.sv
// ---------------------------------------------------------------------------
// bg_index_fetch
//   Turns VGA scan coordinates into 4-bit palette indices read from an
//   external synchronous ROM, with a per-frame wrapping horizontal scroll.
//   Fixed 3-cycle latency, one pixel per clock, no stalls.
//
//   Clk, Reset (async, active-high)
//   DrawX, DrawY, pixel_valid   : scan position and visible flag
//   frame_start, scroll_en      : scroll advance strobe and enable
//   scroll_step                 : columns advanced per frame
//   mirror_x                    : horizontal mirror (only with macro)
//   rom_addr / rom_data         : ROM read port, data valid 1 cycle later
//   idx_out, idx_valid          : palette index and visible flag
//   DrawX_d, DrawY_d            : coordinates aligned with idx_out
//
//   Build option: define BG_FETCH_MIRROR_EN to add the mirror_x input.
// ---------------------------------------------------------------------------
module bg_index_fetch
  import bg_fetch_pkg::*;
#(
  parameter int IMG_W       = DEF_IMG_W,
  parameter int IMG_H       = DEF_IMG_H,
  parameter int SCALE_SHIFT = DEF_SCALE_SHIFT,
  parameter int IDX_W       = DEF_IDX_W,
  parameter int ADDR_W      = DEF_ADDR_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  coord_t            DrawX,
  input  coord_t            DrawY,
  input  logic              pixel_valid,
  input  logic              frame_start,
  input  logic              scroll_en,
  input  logic [3:0]        scroll_step,
`ifdef BG_FETCH_MIRROR_EN
  input  logic              mirror_x,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_data,
  output logic [IDX_W-1:0]  idx_out,
  output logic              idx_valid,
  output coord_t            DrawX_d,
  output coord_t            DrawY_d
);

  localparam int SX_W = $clog2(IMG_W);

  logic [SX_W-1:0]   scroll_x_q, scroll_x_d;
  logic [SX_W:0]     scroll_sum;
  logic              mirror_s;
  logic [ADDR_W-1:0] calc_addr;
  logic              calc_oor;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  logic   vld_p0_q, oor_p0_q;
  coord_t x_p0_q, y_p0_q;
  logic   vld_p1_q, oor_p1_q;
  coord_t x_p1_q, y_p1_q;
  logic   vld_p2_q;
  coord_t x_p2_q, y_p2_q;

`ifdef BG_FETCH_MIRROR_EN
  assign mirror_s = mirror_x;
`else
  assign mirror_s = 1'b0;
`endif

  bg_addr_calc #(
    .IMG_W       (IMG_W),
    .IMG_H       (IMG_H),
    .SCALE_SHIFT (SCALE_SHIFT),
    .ADDR_W      (ADDR_W),
    .SX_W        (SX_W)
  ) u_addr_calc (
    .draw_x_i   (DrawX),
    .draw_y_i   (DrawY),
    .scroll_x_i (scroll_x_q),
    .mirror_i   (mirror_s),
    .addr_o     (calc_addr),
    .oor_o      (calc_oor)
  );

  always_comb begin
    scroll_sum = {1'b0, scroll_x_q} + (SX_W+1)'(scroll_step);
    scroll_x_d = scroll_x_q;
    // The pixel sampled together with frame_start still sees the old scroll.
    if (frame_start && scroll_en) begin
      scroll_x_d = (scroll_sum >= (SX_W+1)'(IMG_W)) ?
                   SX_W'(scroll_sum - (SX_W+1)'(IMG_W)) : SX_W'(scroll_sum);
    end
    // Off-image pixels leave the ROM address untouched.
    rom_addr_d = calc_oor ? rom_addr_q : calc_addr;
    idx_d      = (vld_p1_q && !oor_p1_q) ? rom_data : IDX_W'(TRANSPARENT_IDX);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      scroll_x_q <= '0;
      rom_addr_q <= '0;
      vld_p0_q   <= 1'b0;
      oor_p0_q   <= 1'b0;
      x_p0_q     <= '0;
      y_p0_q     <= '0;
      vld_p1_q   <= 1'b0;
      oor_p1_q   <= 1'b0;
      x_p1_q     <= '0;
      y_p1_q     <= '0;
      vld_p2_q   <= 1'b0;
      idx_q      <= '0;
      x_p2_q     <= '0;
      y_p2_q     <= '0;
    end else begin
      scroll_x_q <= scroll_x_d;
      // S0: address issued to ROM, flags and coordinates captured
      rom_addr_q <= rom_addr_d;
      vld_p0_q   <= pixel_valid;
      oor_p0_q   <= calc_oor;
      x_p0_q     <= DrawX;
      y_p0_q     <= DrawY;
      // S1: ROM read in flight, flags and coordinates follow
      vld_p1_q   <= vld_p0_q;
      oor_p1_q   <= oor_p0_q;
      x_p1_q     <= x_p0_q;
      y_p1_q     <= y_p0_q;
      // S2: index and aligned coordinates presented
      vld_p2_q   <= vld_p1_q;
      idx_q      <= idx_d;
      x_p2_q     <= x_p1_q;
      y_p2_q     <= y_p1_q;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign idx_out   = idx_q;
  assign idx_valid = vld_p2_q;
  assign DrawX_d   = x_p2_q;
  assign DrawY_d   = y_p2_q;

endmodule

// File: tb/tb_bg_index_fetch.sv
`timescale 1ns/1ps
module tb_bg_index_fetch;
  import bg_fetch_pkg::*;

  localparam int IMG_W  = 320;
  localparam int IMG_H  = 240;
  localparam int IDX_W  = 4;
  localparam int ADDR_W = 17;

  typedef struct {
    logic             v;
    logic [IDX_W-1:0] idx;
    logic [9:0]       x;
    logic [9:0]       y;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [9:0]        draw_x, draw_y;
  logic              pix_v, fs, sen, mirror;
  logic [3:0]        sstep;
  logic [ADDR_W-1:0] rom_addr;
  logic [IDX_W-1:0]  rom_data, idx_out;
  logic              idx_valid;
  logic [9:0]        dxd, dyd;

  logic [IDX_W-1:0]  mem [IMG_W*IMG_H];

  int                m_scroll;
  logic [ADDR_W-1:0] m_addr;
  exp_t              q[$];
  int                n_assert = 0;
  int                n_fail   = 0;

  always #5 clk = ~clk;

  // Synchronous ROM: data follows the address by one clock.
  always @(posedge clk) rom_data <= mem[rom_addr];

  bg_index_fetch dut (
    .Clk         (clk),
    .Reset       (rst),
    .DrawX       (draw_x),
    .DrawY       (draw_y),
    .pixel_valid (pix_v),
    .frame_start (fs),
    .scroll_en   (sen),
    .scroll_step (sstep),
`ifdef BG_FETCH_MIRROR_EN
    .mirror_x    (mirror),
`endif
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .idx_out     (idx_out),
    .idx_valid   (idx_valid),
    .DrawX_d     (dxd),
    .DrawY_d     (dyd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"},  32'(rom_addr),  32'd0);
    check({tag, "_idx"},   32'(idx_out),   32'd0);
    check({tag, "_vld"},   32'(idx_valid), 32'd0);
    check({tag, "_xd"},    32'(dxd),       32'd0);
    check({tag, "_yd"},    32'(dyd),       32'd0);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1 check_all_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    m_scroll = 0;
    m_addr   = '0;
    q.delete();
  endtask

  // One pixel clock: drive, clock, then compare against the reference model.
  task automatic step(input int x, input int y, input bit v, input bit f,
                      input bit e, input int st, input bit mir);
    int   src, row, col;
    bit   oor;
    exp_t en;
    draw_x = 10'(x);
    draw_y = 10'(y);
    pix_v  = v;
    fs     = f;
    sen    = e;
    sstep  = 4'(st);
    mirror = mir;
    @(posedge clk);
    #1;
    src = x / 2;
    row = y / 2;
    col = (src + m_scroll) % IMG_W;
`ifdef BG_FETCH_MIRROR_EN
    if (mir) col = IMG_W - 1 - col;
`endif
    oor = (src >= IMG_W) || (row >= IMG_H);
    if (!oor) m_addr = ADDR_W'(row * IMG_W + col);
    en.v   = v;
    en.x   = 10'(x);
    en.y   = 10'(y);
    en.idx = (v && !oor) ? mem[row * IMG_W + col] : '0;
    if (f && e) m_scroll = (m_scroll + st) % IMG_W;
    q.push_back(en);
    check("rom_addr", 32'(rom_addr), 32'(m_addr));
    if (q.size() == 3) begin
      en = q.pop_front();
      check("idx_out",   32'(idx_out),   32'(en.idx));
      check("idx_valid", 32'(idx_valid), 32'(en.v));
      check("DrawX_d",   32'(dxd),       32'(en.x));
      check("DrawY_d",   32'(dyd),       32'(en.y));
    end else begin
      check("idx_out_fill",   32'(idx_out),   32'd0);
      check("idx_valid_fill", 32'(idx_valid), 32'd0);
    end
  endtask

  initial begin
    rst    = 1'b0;
    draw_x = '0;
    draw_y = '0;
    pix_v  = 1'b0;
    fs     = 1'b0;
    sen    = 1'b0;
    sstep  = '0;
    mirror = 1'b0;
    for (int i = 0; i < IMG_W * IMG_H; i++) mem[i] = IDX_W'($urandom);

    do_reset();

    // First pixel after reset, then a scaled coordinate.
    step(0, 0, 1, 0, 0, 0, 0);
    check("t1_addr", 32'(rom_addr), 32'd0);
    step(10, 4, 1, 0, 0, 0, 0);
    check("t2_addr", 32'(rom_addr), 32'd645);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // 22 scroll advances of 15 wrap to 10.
    for (int i = 0; i < 22; i++) begin
      step(0, 0, 0, 1, 1, 15, 0);
      step(0, 0, 0, 0, 1, 15, 0);
    end
    step(630, 0, 1, 0, 0, 0, 0);
    check("t3_addr", 32'(rom_addr), 32'd5);

    // frame_start without enable leaves the scroll alone.
    step(0, 0, 0, 1, 0, 7, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    check("t3_noen_addr", 32'(rom_addr), 32'd10);

    // Off-image row and blanked pixel.
    step(20, 480, 1, 0, 0, 0, 0);
    check("t4_hold_addr", 32'(rom_addr), 32'd10);
    step(20, 6, 0, 0, 0, 0, 0);
    step(1023, 2, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Pixel coinciding with frame_start uses the old scroll.
    step(100, 2, 1, 1, 1, 5, 0);
    check("t5_old_addr", 32'(rom_addr), 32'd380);
    step(100, 2, 1, 0, 0, 0, 0);
    check("t5_new_addr", 32'(rom_addr), 32'd385);

    // Reset mid-line with pixels in flight.
    step(40, 8, 1, 0, 0, 0, 0);
    do_reset();
    step(2, 0, 1, 0, 0, 0, 0);
    step(4, 0, 1, 0, 0, 0, 0);
    step(6, 0, 1, 0, 0, 0, 0);

`ifdef BG_FETCH_MIRROR_EN
    do_reset();
    step(0, 0, 1, 0, 0, 0, 1);
    check("t6_mirror_addr", 32'(rom_addr), 32'd319);
`endif

    // Randomised traffic.
    for (int i = 0; i < 300; i++) begin
      bit mir;
      mir = 1'b0;
`ifdef BG_FETCH_MIRROR_EN
      mir = 1'($urandom);
`endif
      step(int'($urandom_range(0, 1023)), int'($urandom_range(0, 560)),
           $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0,
           1'($urandom), int'($urandom_range(0, 15)), mir);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
